uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_byte_ram_fifo.sv | 82 ++++++++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side byte FIFO.
package uart_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned DEFAULT_DEPTH    = 16;
    localparam int unsigned DEFAULT_GAP_CLKS = 1;

    // Launch sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        GAP    = 2'd3
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_byte_ram_fifo.sv
// Circular byte buffer with registered count/full/empty and a sticky overflow flag.
module uart_byte_ram_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [BYTE_W-1:0]      wr_data,
    input  logic                   pop,
    output logic [BYTE_W-1:0]      head_c,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // DEPTH must be a power of two so the pointers wrap naturally
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_byte_ram_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push_c;
    logic              do_pop_c;
    logic [CNT_W-1:0]  count_nxt_c;

    // Accept/pop decisions; a pop frees a slot for a same-cycle write when full
    always_comb begin
        do_pop_c    = pop && !empty;
        do_push_c   = wr_en && (!full || do_pop_c);
        count_nxt_c = count;
        if (do_push_c && !do_pop_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

    assign head_c = mem[rd_ptr];

    // Storage is not reset; only pointers qualify its contents
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy flags and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == CNT_W'(DEPTH));
            empty <= (count_nxt_c == '0);
            if (wr_en && !do_push_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: launches one byte per frame with an idle gap after each frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned GAP_CLKS = DEFAULT_GAP_CLKS
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Wr_DV,
    input  logic [BYTE_W-1:0]      i_Wr_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic                   o_Overflow,
    output logic                   o_TX_DV,
    output logic [BYTE_W-1:0]      o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done
);

    localparam int unsigned GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    tx_fifo_state_t    state;
    tx_fifo_state_t    state_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_cnt_nxt;
    logic              tx_dv_nxt;
    logic [BYTE_W-1:0] tx_byte_nxt;
    logic              pop_c;
    logic [BYTE_W-1:0] head_c;

    uart_byte_ram_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (i_Clk),
        .rst      (i_Reset),
        .wr_en    (i_Wr_DV),
        .wr_data  (i_Wr_Byte),
        .pop      (pop_c),
        .head_c   (head_c),
        .count    (o_Count),
        .full     (o_Full),
        .empty    (o_Empty),
        .overflow (o_Overflow)
    );

    // Launch sequencer: next state, gap countdown and registered launch outputs
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        tx_dv_nxt   = 1'b0;
        tx_byte_nxt = o_TX_Byte;
        pop_c       = 1'b0;
        case (state)
            IDLE: begin
                if (!o_Empty && !i_TX_Active) begin
                    state_nxt   = LAUNCH;
                    tx_dv_nxt   = 1'b1;
                    tx_byte_nxt = head_c;
                end
            end
            LAUNCH: begin
                pop_c     = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                // Done is honoured here regardless of the active indication
                if (i_TX_Done) begin
                    if (GAP_CLKS == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_W'(GAP_CLKS - 1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state and launch output registers
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= '0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_cnt_nxt;
            o_TX_DV   <= tx_dv_nxt;
            o_TX_Byte <= tx_byte_nxt;
        end
    end

endmodule
